// File: rtl/hamming_link_scheduler_if.sv
// rtl/hamming_link_scheduler_if.sv - requester and serial-link signal bundle for hamming_link_scheduler
interface hamming_link_scheduler_if;
    logic [3:0]  req;
    logic [15:0] data_in;
    logic [3:0]  gnt;
    logic        ser_d;
    logic        ser_strobe;
    logic [1:0]  ser_lane;
    logic        busy;
    logic [7:0]  frame_cnt;

    modport master (
        output req, data_in,
        input  gnt, ser_d, ser_strobe, ser_lane, busy, frame_cnt
    );

    modport slave (
        input  req, data_in,
        output gnt, ser_d, ser_strobe, ser_lane, busy, frame_cnt
    );
endinterface

// File: rtl/hamming_link_scheduler.sv
// rtl/hamming_link_scheduler.sv - round-robin arbiter feeding a strobed serial Hamming(7,4) link
module hamming_link_scheduler #(
    parameter int GAP_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    hamming_link_scheduler_if.slave link
);
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam logic [3:0] GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n;
    logic [1:0] lane, lane_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [3:0] gap_cnt, gap_cnt_n;
    logic [6:0] shreg, shreg_n;
    logic [3:0] gnt, gnt_n;
    logic       ser_d, ser_d_n;
    logic       strobe, strobe_n;
    logic       busy, busy_n;
    logic [7:0] frame_cnt, frame_cnt_n;

    logic       found;
    logic [1:0] winner;
    logic [1:0] cand;
    logic [3:0] nib;
    logic [6:0] cw;

    // Search starts one past the last winner so every lane gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        cand   = ptr;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && link.req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign nib = link.data_in[{winner, 2'b00} +: 4];

    // Codeword bit 6 goes out first: p1, p2, d1, p4, d2, d3, d4.
    assign cw = {nib[3] ^ nib[2] ^ nib[0],
                 nib[3] ^ nib[1] ^ nib[0],
                 nib[3],
                 nib[2] ^ nib[1] ^ nib[0],
                 nib[2],
                 nib[1],
                 nib[0]};

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        lane_n      = lane;
        bit_cnt_n   = bit_cnt;
        gap_cnt_n   = gap_cnt;
        shreg_n     = shreg;
        gnt_n       = 4'b0000;
        ser_d_n     = 1'b0;
        strobe_n    = 1'b0;
        busy_n      = busy;
        frame_cnt_n = frame_cnt;

        case (state)
            IDLE: begin
                busy_n = 1'b0;
                if (found) begin
                    state_n   = SEND;
                    ptr_n     = winner;
                    lane_n    = winner;
                    shreg_n   = cw;
                    bit_cnt_n = 3'd0;
                    gnt_n     = 4'b0001 << winner;
                    strobe_n  = 1'b1;
                    ser_d_n   = cw[6];
                    busy_n    = 1'b1;
                end
            end
            SEND: begin
                busy_n = 1'b1;
                if (bit_cnt == 3'd6) begin
                    frame_cnt_n = frame_cnt + 8'd1;
                    if (GAP_CYCLES > 0) begin
                        state_n   = GAP;
                        gap_cnt_n = 4'd0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    shreg_n   = shreg << 1;
                    strobe_n  = 1'b1;
                    ser_d_n   = shreg[5];
                end
            end
            GAP: begin
                busy_n = 1'b1;
                if (gap_cnt == GAP_LAST) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    gap_cnt_n = gap_cnt + 4'd1;
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            lane      <= 2'd0;
            bit_cnt   <= 3'd0;
            gap_cnt   <= 4'd0;
            shreg     <= 7'd0;
            gnt       <= 4'b0000;
            ser_d     <= 1'b0;
            strobe    <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            lane      <= lane_n;
            bit_cnt   <= bit_cnt_n;
            gap_cnt   <= gap_cnt_n;
            shreg     <= shreg_n;
            gnt       <= gnt_n;
            ser_d     <= ser_d_n;
            strobe    <= strobe_n;
            busy      <= busy_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    assign link.gnt        = gnt;
    assign link.ser_d      = ser_d;
    assign link.ser_strobe = strobe;
    assign link.ser_lane   = lane;
    assign link.busy       = busy;
    assign link.frame_cnt  = frame_cnt;
endmodule

// File: tb/tb_hamming_link_scheduler.sv
// tb/tb_hamming_link_scheduler.sv - scoreboard bench for hamming_link_scheduler with GAP 1 and GAP 0 instances
module tb_hamming_link_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_link_scheduler_if if1();
    hamming_link_scheduler_if if0();

    hamming_link_scheduler #(.GAP_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .link(if1));
    hamming_link_scheduler #(.GAP_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .link(if0));

    typedef struct packed {
        logic [1:0] lane;
        logic [6:0] cw;
    } frame_t;

    frame_t q1[$];
    frame_t q0[$];
    int vectors = 0;
    int miscompares = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    logic [1:0] m_strobe, m_d;
    logic [1:0] m_lane [2];
    logic [3:0] m_gnt [2];
    logic       m_busy [2];
    logic [7:0] m_fcnt [2];
    assign m_strobe = {if1.ser_strobe, if0.ser_strobe};
    assign m_d      = {if1.ser_d, if0.ser_d};
    assign m_lane[1] = if1.ser_lane;
    assign m_lane[0] = if0.ser_lane;
    assign m_gnt[1]  = if1.gnt;
    assign m_gnt[0]  = if0.gnt;
    assign m_busy[1] = if1.busy;
    assign m_busy[0] = if0.busy;
    assign m_fcnt[1] = if1.frame_cnt;
    assign m_fcnt[0] = if0.frame_cnt;

    function automatic logic [6:0] encode(input logic [3:0] n);
        logic d1, d2, d3, d4;
        d1 = n[3]; d2 = n[2]; d3 = n[1]; d4 = n[0];
        return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    int nbits [2] = '{0, 0};
    int low [2] = '{0, 0};
    int last_low [2] = '{0, 0};
    logic [6:0] sh [2];
    logic [6:0] last_cw [2];
    logic [1:0] ln [2];
    frame_t e_mon;
    int qsize;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                nbits[k] = 0;
                low[k]   = 0;
                if (k == 1) q1.delete(); else q0.delete();
            end else if (m_strobe[k]) begin
                if (nbits[k] == 0) begin
                    last_low[k] = low[k];
                    ln[k] = m_lane[k];
                end else begin
                    check("ser_lane_stable", 32'(m_lane[k]), 32'(ln[k]));
                end
                sh[k] = {sh[k][5:0], m_d[k]};
                nbits[k]++;
                low[k] = 0;
            end else begin
                check("ser_d_low_outside_frame", 32'(m_d[k]), 32'd0);
                if (nbits[k] > 0) begin
                    check("strobe_len", nbits[k], 7);
                    qsize = (k == 1) ? q1.size() : q0.size();
                    check("sb_nonempty", 32'(qsize > 0), 32'd1);
                    if (qsize > 0) begin
                        e_mon = (k == 1) ? q1.pop_front() : q0.pop_front();
                        check("frame_cw", 32'(sh[k]), 32'(e_mon.cw));
                        check("frame_lane", 32'(ln[k]), 32'(e_mon.lane));
                    end
                    last_cw[k] = sh[k];
                    nbits[k] = 0;
                end
                low[k]++;
            end
        end
    end

    int unsigned prev_g [2] = '{0, 0};

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic next_gnt(input int k, output logic [3:0] g, output int per);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        g = 4'b0000;
        while (!hit && n < 100) begin
            step();
            n++;
            if (m_gnt[k] != 4'b0000) hit = 1'b1;
        end
        check("gnt_within_budget", 32'(hit), 32'd1);
        g = m_gnt[k];
        per = int'(cyc - prev_g[k]);
        prev_g[k] = cyc;
    endtask

    task automatic wait_idle(input int k);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (m_busy[k] && n < 64);
        check("idle_within_budget", 32'(m_busy[k]), 32'd0);
    endtask

    logic [3:0] g;
    int per;
    logic [3:0] w;

    initial begin
        if1.req = 4'b0000; if1.data_in = 16'h0000;
        if0.req = 4'b0000; if0.data_in = 16'h0000;
        rst = 1'b1;
        repeat (3) step();
        check("rst_gnt", 32'(if1.gnt), 32'd0);
        check("rst_strobe", 32'(if1.ser_strobe), 32'd0);
        check("rst_ser_d", 32'(if1.ser_d), 32'd0);
        check("rst_lane", 32'(if1.ser_lane), 32'd0);
        check("rst_busy", 32'(if1.busy), 32'd0);
        check("rst_frame_cnt", 32'(if1.frame_cnt), 32'd0);
        rst = 1'b0;
        step();

        // single frame on lane 2
        if1.data_in = 16'h0B00;
        if1.req = 4'b0100;
        q1.push_back({2'd2, encode(4'b1011)});
        next_gnt(1, g, per);
        check("t1_gnt", 32'(g), 32'b0100);
        check("t1_strobe", 32'(if1.ser_strobe), 32'd1);
        check("t1_lane", 32'(if1.ser_lane), 32'd2);
        if1.req = 4'b0000;
        step();
        check("t1_gnt_pulse", 32'(if1.gnt), 32'd0);
        wait_idle(1);
        check("t1_codeword", 32'(last_cw[1]), 32'b0110011);
        check("t1_frame_cnt", 32'(if1.frame_cnt), 32'd1);

        // all-zero then all-one nibbles on lane 0
        if1.data_in = 16'h0000;
        if1.req = 4'b0001;
        q1.push_back({2'd0, 7'b0000000});
        next_gnt(1, g, per);
        check("t2_gnt0", 32'(g), 32'b0001);
        if1.data_in = 16'h000F;
        q1.push_back({2'd0, 7'b1111111});
        next_gnt(1, g, per);
        check("t2_gnt1", 32'(g), 32'b0001);
        check("t2_period", per, 9);
        if1.req = 4'b0000;
        wait_idle(1);
        check("t2_codeword", 32'(last_cw[1]), 32'b1111111);
        check("t2_frame_cnt", 32'(if1.frame_cnt), 32'd3);

        // all lanes requesting from reset
        rst = 1'b1;
        if1.req = 4'b1111;
        if1.data_in = 16'h9B63;
        step();
        step();
        rst = 1'b0;
        q1.push_back({2'd0, encode(4'h3)});
        q1.push_back({2'd1, encode(4'h6)});
        q1.push_back({2'd2, encode(4'hB)});
        q1.push_back({2'd3, encode(4'h9)});
        q1.push_back({2'd0, encode(4'h3)});
        for (int i = 0; i < 5; i++) begin
            next_gnt(1, g, per);
            check("t3_rr_order", 32'(g), 32'(4'b0001 << (i % 4)));
            if (i > 0) begin
                check("t3_period", per, 9);
                check("t3_low_cycles", last_low[1], 2);
            end
            if (i == 4) if1.req = 4'b0000;
        end
        wait_idle(1);

        // pointer moves past lane 3 to lane 1, then back to lane 3
        if1.req = 4'b1000;
        q1.push_back({2'd3, encode(4'h9)});
        next_gnt(1, g, per);
        check("t4_gnt3", 32'(g), 32'b1000);
        if1.req = 4'b1010;
        q1.push_back({2'd1, encode(4'h6)});
        q1.push_back({2'd3, encode(4'h9)});
        next_gnt(1, g, per);
        check("t4_gnt1", 32'(g), 32'b0010);
        next_gnt(1, g, per);
        check("t4_gnt3_again", 32'(g), 32'b1000);
        if1.req = 4'b0000;
        wait_idle(1);

        // reset on the 4th bit of a lane-1 frame
        if1.req = 4'b0010;
        q1.push_back({2'd1, encode(4'h6)});
        next_gnt(1, g, per);
        check("t5_gnt1", 32'(g), 32'b0010);
        if1.req = 4'b0000;
        repeat (3) step();
        check("t5_mid_frame", 32'(if1.ser_strobe), 32'd1);
        rst = 1'b1;
        if1.req = 4'b1111;
        step();
        check("t5_strobe", 32'(if1.ser_strobe), 32'd0);
        check("t5_ser_d", 32'(if1.ser_d), 32'd0);
        check("t5_busy", 32'(if1.busy), 32'd0);
        check("t5_frame_cnt", 32'(if1.frame_cnt), 32'd0);
        check("t5_gnt", 32'(if1.gnt), 32'd0);
        q1.push_back({2'd0, encode(4'h3)});
        rst = 1'b0;
        next_gnt(1, g, per);
        check("t5_first_after_rst", 32'(g), 32'b0001);
        if1.req = 4'b0000;
        wait_idle(1);
        check("t5_frame_cnt_after", 32'(if1.frame_cnt), 32'd1);

        // 256 back-to-back frames with no gap, data disturbed mid-frame
        w = 4'h0;
        if0.data_in = {12'h000, w};
        if0.req = 4'b0001;
        for (int f = 1; f <= 256; f++) begin
            next_gnt(0, g, per);
            check("t6_gnt", 32'(g), 32'b0001);
            check("t6_frame_cnt", 32'(if0.frame_cnt), 32'((f - 1) % 256));
            if (f > 1) begin
                check("t6_period", per, 8);
                check("t6_low_cycles", last_low[0], 1);
            end
            q0.push_back({2'd0, encode(w)});
            if (f == 256) if0.req = 4'b0000;
            if0.data_in = {12'hA5C, ~w};
            repeat (3) step();
            w = w + 4'd3;
            if0.data_in = {12'h000, w};
        end
        wait_idle(0);
        check("t6_frame_cnt_wrap", 32'(if0.frame_cnt), 32'd0);
        check("sb1_drained", q1.size(), 0);
        check("sb0_drained", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hamming_link_scheduler.md
Name: hamming_link_scheduler

Overview:
Shares one serial Hamming(7,4) link between four 4-bit requesters (one per nibble lane of the router output). Round-robin arbitration picks a lane, then the block encodes its nibble and serialises the 7-bit codeword under a strobe frame. The frame format is the one the error_inject/error_correct lanes consume. The block sits between secure_router outputs and the link, and replaces the free-running strobe counter in the top level.

Parameters:
GAP_CYCLES, 1, extra strobe-low cycles after each frame, legal range 0..15.

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
req  in  4  per-lane request; bit i means lane i has a word pending
data_in  in  16  lane i nibble on data_in[4i+3:4i]; must be held stable while req[i]=1
gnt  out  4  one-hot, one-cycle pulse; lane i word has been captured
ser_d  out  1  serial codeword bit
ser_strobe  out  1  high for exactly the 7 codeword-bit cycles of a frame
ser_lane  out  2  index of the lane being sent; valid while ser_strobe=1
busy  out  1  high in SEND and GAP states
frame_cnt  out  8  count of completed frames, wraps 255->0

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer = 3 so lane 0 has first priority, shift register cleared.
- Reset asserted mid-frame: the next cycle shows ser_strobe=0 and ser_d=0. The frame is dropped, frame_cnt is cleared and no gnt is issued.
- FSM states: IDLE, SEND, GAP. All outputs are registered.
- IDLE: if req=0, stay. Otherwise take the first set bit searching ptr+1, ptr+2, ... modulo 4. At that edge:
  - latch the codeword and lane index; ptr <= winner;
  - go to SEND with bit counter = 0;
  - gnt[winner]=1 during the following cycle only.
- Encoding: d1=data[3], d2=data[2], d3=data[1], d4=data[0].
  - p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4.
  - Transmit order: p1, p2, d1, p4, d2, d3, d4 (codeword position 1 first).
- SEND: lasts 7 cycles. ser_strobe=1 and ser_d = current bit; the first bit appears in the same cycle as gnt.
  - After the 7th bit: frame_cnt increments.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP: GAP_CYCLES cycles with ser_strobe=0 and ser_d=0, then IDLE.
- Frame spacing: between frames ser_strobe is low for at least GAP_CYCLES+1 cycles (IDLE included). This guarantees a frame delimiter.
- Back-to-back period: 8+GAP_CYCLES cycles.
- req is sampled only in IDLE. Changes to req or data_in during SEND/GAP are ignored; the captured word is unaffected.
- Requester rule: on seeing gnt, drop req or present the next word. If req[i] is still high at the next IDLE, it is treated as a new word.
- Outside SEND: ser_d=0; ser_lane holds its last value (don't-care).
- busy=1 exactly when state is SEND or GAP.

Test Plan:
1. rst, then req=4'b0100, data_in[11:8]=4'b1011, GAP=1.
   -> gnt=4'b0100 for one cycle.
   -> ser_strobe high 7 cycles with ser_lane=2 and ser_d sequence 0,1,1,0,0,1,1.
   -> frame_cnt=1.
2. Lane 0 data 4'b0000, then 4'b1111. -> ser_d all 0s, then all 1s (1111111), each frame with 7 strobe cycles.
3. req=4'b1111 held continuously from reset, GAP=1.
   -> grant order 0,1,2,3,0.
   -> exactly 2 strobe-low cycles between frames; period 9 cycles.
4. After lane 3 is granted, set req=4'b1010 -> lane 1 is granted next, then lane 3.
5. Assert rst on the 4th bit of a frame.
   -> next cycle ser_strobe=0, busy=0, frame_cnt=0.
   -> with req=4'b1111 afterwards, lane 0 is granted first.
6. GAP=0 with 256 back-to-back frames.
   -> frame_cnt wraps to 0.
   -> exactly 1 strobe-low cycle between frames.
   -> toggling data_in mid-frame leaves the serial bits unchanged.
